// File: rtl/rw_request_scheduler.sv
// Round-robin scheduler sharing one read/write transaction FSM between
// two requesters, with per-transaction retry and timeout handling.
module rw_request_scheduler #(
   parameter int MAX_RETRY = 3,
   parameter int TIMEOUT   = 200
) (
   input  logic        clk,
   input  logic        rst_b,
   input  logic [1:0]  req_valid,
   input  logic [1:0]  req_write,
   input  logic [15:0] req_addr0,
   input  logic [15:0] req_addr1,
   input  logic [63:0] req_data0,
   input  logic [63:0] req_data1,
   output logic [1:0]  req_ready,
   output logic [1:0]  resp_valid,
   output logic        resp_ok,
   output logic [63:0] resp_data,
   output logic        fsm_read,
   output logic        fsm_write,
   output logic [15:0] fsm_mempage,
   output logic [63:0] fsm_data_from_OS,
   input  logic        fsm_done,
   input  logic        fsm_ok,
   input  logic [63:0] fsm_data_to_OS,
   output logic        busy
);

   localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT - 1);
   localparam logic [3:0] RETRY_MAX = 4'(MAX_RETRY);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESPOND
   } state_t;

   state_t      state;
   state_t      state_nxt;

   logic        ptr;
   logic        gnt;
   logic        gnt_sel;
   logic        lat_write;
   logic [3:0]  retry_cnt;
   logic [7:0]  timer;

   logic        take;
   logic        timeout;
   logic        can_retry;
   logic        fail;

   logic [1:0]  req_ready_d;
   logic [1:0]  resp_valid_d;
   logic        fsm_read_d;
   logic        fsm_write_d;
   logic        ok_d;
   logic [63:0] rdata_d;

   assign take      = (state == IDLE) && (|req_valid);
   assign timeout   = (timer == TMO_LAST);
   assign can_retry = (retry_cnt < RETRY_MAX);
   // a done pulse always wins over a coincident timeout
   assign fail      = fsm_done ? !fsm_ok : timeout;

   always_comb begin
      gnt_sel = ~ptr;
      unique case (1'b1)
         req_valid[ptr]: gnt_sel = ptr;
         default:        gnt_sel = ~ptr;
      endcase
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (|req_valid) begin
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            state_nxt = WAIT;
         end
         WAIT: begin
            if (fsm_done || timeout) begin
               if (fail && can_retry) begin
                  state_nxt = ISSUE;
               end else begin
                  state_nxt = RESPOND;
               end
            end
         end
         RESPOND: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_comb begin
      req_ready_d  = 2'b00;
      resp_valid_d = 2'b00;
      fsm_read_d   = 1'b0;
      fsm_write_d  = 1'b0;
      ok_d         = resp_ok;
      rdata_d      = resp_data;
      if (take) begin
         req_ready_d = gnt_sel ? 2'b10 : 2'b01;
         fsm_write_d = req_write[gnt_sel];
         fsm_read_d  = !req_write[gnt_sel];
      end else if (state == WAIT && state_nxt == ISSUE) begin
         fsm_write_d = lat_write;
         fsm_read_d  = !lat_write;
      end
      if (state == WAIT && state_nxt == RESPOND) begin
         resp_valid_d = gnt ? 2'b10 : 2'b01;
         ok_d         = fsm_done && fsm_ok;
         rdata_d      = 64'd0;
         if (fsm_done && fsm_ok && !lat_write) begin
            rdata_d = fsm_data_to_OS;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         req_ready  <= 2'b00;
         resp_valid <= 2'b00;
         fsm_read   <= 1'b0;
         fsm_write  <= 1'b0;
         resp_ok    <= 1'b0;
         resp_data  <= 64'd0;
         busy       <= 1'b0;
      end else begin
         req_ready  <= req_ready_d;
         resp_valid <= resp_valid_d;
         fsm_read   <= fsm_read_d;
         fsm_write  <= fsm_write_d;
         resp_ok    <= ok_d;
         resp_data  <= rdata_d;
         busy       <= (state_nxt != IDLE);
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         ptr              <= 1'b0;
         gnt              <= 1'b0;
         lat_write        <= 1'b0;
         fsm_mempage      <= 16'd0;
         fsm_data_from_OS <= 64'd0;
      end else begin
         if (take) begin
            gnt              <= gnt_sel;
            lat_write        <= req_write[gnt_sel];
            fsm_mempage      <= gnt_sel ? req_addr1 : req_addr0;
            fsm_data_from_OS <= gnt_sel ? req_data1 : req_data0;
         end
         if (state == RESPOND) begin
            ptr <= ~gnt;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         retry_cnt <= 4'd0;
         timer     <= 8'd0;
      end else begin
         if (take) begin
            retry_cnt <= 4'd0;
         end else if (state == WAIT && state_nxt == ISSUE) begin
            retry_cnt <= retry_cnt + 4'd1;
         end
         if (state == ISSUE) begin
            timer <= 8'd0;
         end else if (state == WAIT) begin
            timer <= timer + 8'd1;
         end
      end
   end

endmodule
